wm_cycle_controller: RTL and testbench

//  Parametrised washing-machine cycle sequencer, next generation of the coin-operated controller.

---
 rtl/wm_pkg.sv | 26 ++
 rtl/wm_phase_timer.sv | 36 +++
 rtl/wm_cycle_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_wm_cycle_controller.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared encodings for the washing-machine cycle sequencer: phase states and program bits.
package wm_pkg;

    localparam int PHASE_W = 4;

    typedef enum logic [PHASE_W-1:0] {
        ST_IDLE  = 4'd0,
        ST_READY = 4'd1,
        ST_FILL  = 4'd2,
        ST_HEAT  = 4'd3,
        ST_SOAK  = 4'd4,
        ST_WASH  = 4'd5,
        ST_RINSE = 4'd6,
        ST_SPIN  = 4'd7,
        ST_DONE  = 4'd8,
        ST_FAULT = 4'd9
    } state_t;

    localparam int PROG_QUICK = 0;
    localparam int PROG_COLD  = 1;

    function automatic logic is_timed(input state_t s);
        return (s == ST_SOAK) || (s == ST_WASH) || (s == ST_RINSE) || (s == ST_SPIN);
    endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Loadable down-counter shared by the timed phases and the FILL/HEAT timeouts.
module wm_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count_next,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    // Load has priority; the count never wraps below zero.
    always_comb begin
        w_count_next = r_count;
        if (i_load)
            w_count_next = i_load_val;
        else if (i_dec && (r_count != '0))
            w_count_next = r_count - 1'b1;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_count <= '0;
        else
            r_count <= w_count_next;
    end

    assign o_count_next = w_count_next;
    assign o_zero       = (r_count == '0);

endmodule

// File: rtl/wm_cycle_controller.sv
// Coin-operated washing-machine sequencer: coin/refund handling, phase FSM, registered outputs.
module wm_cycle_controller
    import wm_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int COINS_REQ    = 2,
    parameter int SOAK_CYCLES  = 400,
    parameter int WASH_CYCLES  = 1000,
    parameter int RINSE_CYCLES = 600,
    parameter int RINSE_PASSES = 2,
    parameter int SPIN_CYCLES  = 500,
    parameter int FILL_TIMEOUT = 300,
    parameter int HEAT_TIMEOUT = 800
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_coin,
    input  logic               i_start,
    input  logic               i_cancel,
    input  logic               i_lid_open,
    input  logic               i_water_full,
    input  logic               i_water_hot,
    input  logic [1:0]         i_program,
    output logic               o_idle,
    output logic               o_ready,
    output logic               o_water_intake,
    output logic               o_heater_on,
    output logic               o_soak_operation,
    output logic               o_wash_operation,
    output logic               o_rinse_operation,
    output logic               o_spin_operation,
    output logic               o_done,
    output logic               o_coin_return,
    output logic               o_fault,
    output logic [PHASE_W-1:0] o_phase,
    output logic [CNT_W-1:0]   o_remaining
);

    localparam logic [3:0]       COINS_MAX = 4'(COINS_REQ);
    localparam logic [2:0]       LAST_PASS = 3'(RINSE_PASSES - 1);
    localparam logic [CNT_W-1:0] FILL_LD   = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HEAT_LD   = CNT_W'(HEAT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SOAK_LD   = CNT_W'(SOAK_CYCLES - 1);
    localparam logic [CNT_W-1:0] WASH_LD   = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RINSE_LD  = CNT_W'(RINSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPIN_LD   = CNT_W'(SPIN_CYCLES - 1);

    state_t           r_state, w_state_next;
    logic [3:0]       r_coin_cnt, w_coin_cnt_next;
    logic [2:0]       r_rinse_pass, w_rinse_pass_next;
    logic [1:0]       r_program, w_program_next;
    logic             w_refund;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic [CNT_W-1:0] w_timer_next;
    logic             w_timer_zero;
    state_t           w_after_fill;
    state_t           w_after_heat;

    wm_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_load       (w_load),
        .i_load_val   (w_load_val),
        .i_dec        (w_dec),
        .o_count_next (w_timer_next),
        .o_zero       (w_timer_zero)
    );

    function automatic logic [CNT_W-1:0] load_for(input state_t s);
        case (s)
            ST_FILL:  return FILL_LD;
            ST_HEAT:  return HEAT_LD;
            ST_SOAK:  return SOAK_LD;
            ST_WASH:  return WASH_LD;
            ST_RINSE: return RINSE_LD;
            ST_SPIN:  return SPIN_LD;
            default:  return '0;
        endcase
    endfunction

    assign w_after_heat = r_program[PROG_QUICK] ? ST_WASH : ST_SOAK;
    assign w_after_fill = r_program[PROG_COLD] ? w_after_heat : ST_HEAT;

    always_comb begin
        w_state_next      = r_state;
        w_coin_cnt_next   = r_coin_cnt;
        w_rinse_pass_next = r_rinse_pass;
        w_program_next    = r_program;
        w_refund          = 1'b0;
        w_load            = 1'b0;
        w_load_val        = '0;
        w_dec             = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A coin arriving with cancel is returned along with any already inserted.
                if (i_cancel && ((r_coin_cnt != '0) || i_coin)) begin
                    w_refund        = 1'b1;
                    w_coin_cnt_next = '0;
                end else if (i_coin) begin
                    w_coin_cnt_next = r_coin_cnt + 4'd1;
                    if (w_coin_cnt_next == COINS_MAX)
                        w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (i_cancel) begin
                    w_refund        = 1'b1;
                    w_coin_cnt_next = '0;
                    w_state_next    = ST_IDLE;
                end else begin
                    w_refund = i_coin;
                    if (i_start && !i_lid_open) begin
                        w_coin_cnt_next = '0;
                        w_program_next  = i_program;
                        w_state_next    = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                w_dec = 1'b1;
                if (i_cancel)          w_state_next = ST_SPIN;
                else if (i_water_full) w_state_next = w_after_fill;
                else if (w_timer_zero) w_state_next = ST_FAULT;
            end
            ST_HEAT: begin
                w_dec = 1'b1;
                if (i_cancel)          w_state_next = ST_SPIN;
                else if (i_water_hot)  w_state_next = w_after_heat;
                else if (w_timer_zero) w_state_next = ST_FAULT;
            end
            ST_SOAK, ST_WASH, ST_SPIN: begin
                if (i_cancel && (r_state != ST_SPIN)) begin
                    w_state_next = ST_SPIN;
                end else if (!i_lid_open) begin
                    w_dec = 1'b1;
                    if (w_timer_zero) begin
                        case (r_state)
                            ST_SOAK: w_state_next = ST_WASH;
                            ST_WASH: w_state_next = ST_RINSE;
                            default: w_state_next = ST_DONE;
                        endcase
                        w_rinse_pass_next = '0;
                    end
                end
            end
            ST_RINSE: begin
                if (i_cancel) begin
                    w_state_next = ST_SPIN;
                end else if (!i_lid_open) begin
                    w_dec = 1'b1;
                    if (w_timer_zero) begin
                        if (r_rinse_pass == LAST_PASS) begin
                            w_state_next = ST_SPIN;
                        end else begin
                            w_rinse_pass_next = r_rinse_pass + 3'd1;
                            w_load            = 1'b1;
                            w_load_val        = RINSE_LD;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (i_lid_open) begin
                    w_state_next    = ST_IDLE;
                    w_coin_cnt_next = '0;
                end
            end
            default: ;
        endcase

        if (w_state_next != r_state) begin
            w_load     = 1'b1;
            w_load_val = load_for(w_state_next);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_coin_cnt   <= '0;
            r_rinse_pass <= '0;
            r_program    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_coin_cnt   <= w_coin_cnt_next;
            r_rinse_pass <= w_rinse_pass_next;
            r_program    <= w_program_next;
        end
    end

    // Outputs decode the next state so they line up with the state register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_idle            <= 1'b1;
            o_ready           <= 1'b0;
            o_water_intake    <= 1'b0;
            o_heater_on       <= 1'b0;
            o_soak_operation  <= 1'b0;
            o_wash_operation  <= 1'b0;
            o_rinse_operation <= 1'b0;
            o_spin_operation  <= 1'b0;
            o_done            <= 1'b0;
            o_coin_return     <= 1'b0;
            o_fault           <= 1'b0;
            o_phase           <= ST_IDLE;
            o_remaining       <= '0;
        end else begin
            o_idle            <= (w_state_next == ST_IDLE);
            o_ready           <= (w_state_next == ST_READY);
            o_water_intake    <= (w_state_next == ST_FILL);
            o_heater_on       <= (w_state_next == ST_HEAT);
            o_soak_operation  <= (w_state_next == ST_SOAK)  && !i_lid_open;
            o_wash_operation  <= (w_state_next == ST_WASH)  && !i_lid_open;
            o_rinse_operation <= (w_state_next == ST_RINSE) && !i_lid_open;
            o_spin_operation  <= (w_state_next == ST_SPIN)  && !i_lid_open;
            o_done            <= (w_state_next == ST_DONE);
            o_coin_return     <= w_refund;
            o_fault           <= (w_state_next == ST_FAULT);
            o_phase           <= w_state_next;
            o_remaining       <= is_timed(w_state_next) ? (w_timer_next + 1'b1) : '0;
        end
    end

endmodule

// File: tb/tb_wm_cycle_controller.sv
// Directed bench for wm_cycle_controller with short phase lengths and hand-computed expectations.
module tb_wm_cycle_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        coin, start, cancel, lid_open, water_full, water_hot;
    logic [1:0]  program_sel;
    logic        o_idle, o_ready, o_water_intake, o_heater_on;
    logic        o_soak_operation, o_wash_operation, o_rinse_operation, o_spin_operation;
    logic        o_done, o_coin_return, o_fault;
    logic [3:0]  o_phase;
    logic [15:0] o_remaining;

    int n_vec = 0;
    int n_err = 0;
    int n_ret = 0;
    int n     = 0;
    int ret0  = 0;

    localparam logic [3:0] P_IDLE = 4'd0, P_READY = 4'd1, P_FILL = 4'd2, P_HEAT = 4'd3,
                           P_SOAK = 4'd4, P_WASH = 4'd5, P_RINSE = 4'd6, P_SPIN = 4'd7,
                           P_DONE = 4'd8, P_FAULT = 4'd9;
    localparam logic [10:0] F_IDLE_ONLY  = 11'b100_0000_0000;
    localparam logic [10:0] F_FAULT_ONLY = 11'b000_0000_0001;

    wire [10:0] flags = {o_idle, o_ready, o_water_intake, o_heater_on, o_soak_operation,
                         o_wash_operation, o_rinse_operation, o_spin_operation, o_done,
                         o_coin_return, o_fault};

    always #5 clk = ~clk;

    wm_cycle_controller #(
        .CNT_W(16), .COINS_REQ(2), .SOAK_CYCLES(4), .WASH_CYCLES(8), .RINSE_CYCLES(3),
        .RINSE_PASSES(2), .SPIN_CYCLES(5), .FILL_TIMEOUT(6), .HEAT_TIMEOUT(6)
    ) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_coin(coin), .i_start(start), .i_cancel(cancel),
        .i_lid_open(lid_open), .i_water_full(water_full), .i_water_hot(water_hot),
        .i_program(program_sel), .o_idle(o_idle), .o_ready(o_ready),
        .o_water_intake(o_water_intake), .o_heater_on(o_heater_on),
        .o_soak_operation(o_soak_operation), .o_wash_operation(o_wash_operation),
        .o_rinse_operation(o_rinse_operation), .o_spin_operation(o_spin_operation),
        .o_done(o_done), .o_coin_return(o_coin_return), .o_fault(o_fault),
        .o_phase(o_phase), .o_remaining(o_remaining)
    );

    task automatic step();
        @(posedge clk);
        #1;
        n_ret += int'(o_coin_return);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts consecutive samples spent in phase ph, bounded so a stuck DUT cannot hang the run.
    task automatic measure(input logic [3:0] ph, output int cnt);
        cnt = 0;
        while (o_phase == ph && cnt < 200) begin
            cnt++;
            step();
        end
    endtask

    task automatic arm_and_start(input logic [1:0] prog);
        coin = 1'b1; step(); step(); coin = 1'b0;
        program_sel = prog;
        start = 1'b1; step(); start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; coin = 0; start = 0; cancel = 0; lid_open = 0;
        water_full = 0; water_hot = 0; program_sel = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", 32'(flags), 32'(F_IDLE_ONLY));
        check("reset_phase", 32'(o_phase), 32'(P_IDLE));
        check("reset_remaining", 32'(o_remaining), 32'd0);
        rst_n = 1'b1;

        // Normal program, full cycle
        coin = 1'b1; step();
        check("one_coin_not_ready", 32'(o_ready), 32'd0);
        step(); coin = 1'b0;
        check("two_coins_ready", 32'(o_phase), 32'(P_READY));
        start = 1'b1; step(); start = 1'b0;
        check("fill_entry", 32'(o_water_intake), 32'd1);
        step();
        water_full = 1'b1; step(); water_full = 1'b0;
        check("heat_entry", 32'(o_heater_on), 32'd1);
        step();
        water_hot = 1'b1; step(); water_hot = 1'b0;
        check("soak_entry", 32'(o_soak_operation), 32'd1);
        check("soak_remaining", 32'(o_remaining), 32'd4);
        measure(P_SOAK, n);
        check("soak_len", 32'(n), 32'd4);
        check("wash_remaining", 32'(o_remaining), 32'd8);
        measure(P_WASH, n);
        check("wash_len", 32'(n), 32'd8);
        measure(P_RINSE, n);
        check("rinse_len", 32'(n), 32'd6);
        check("spin_remaining", 32'(o_remaining), 32'd5);
        measure(P_SPIN, n);
        check("spin_len", 32'(n), 32'd5);
        check("done_set", 32'(o_done), 32'd1);
        step();
        check("done_hold", 32'(o_phase), 32'(P_DONE));
        lid_open = 1'b1; step(); lid_open = 1'b0;
        check("done_lid_idle", 32'(flags), 32'(F_IDLE_ONLY));
        check("no_refund_cycle1", 32'(n_ret), 32'd0);

        // Cancel with one coin, then cancel with none
        coin = 1'b1; step(); coin = 1'b0;
        cancel = 1'b1; step();
        check("cancel_refund", 32'({o_coin_return, o_idle}), 32'b11);
        step(); cancel = 1'b0;
        check("second_cancel_no_pulse", 32'(o_coin_return), 32'd0);
        check("single_refund", 32'(n_ret), 32'd1);
        coin = 1'b1; step();
        check("coin_cnt_cleared", 32'(o_ready), 32'd0);
        step(); coin = 1'b0;
        check("rearmed", 32'(o_phase), 32'(P_READY));

        // Start with lid open is ignored; an extra coin in READY is returned
        lid_open = 1'b1; start = 1'b1; step(); start = 1'b0; lid_open = 1'b0;
        check("lid_start_ignored", 32'(o_phase), 32'(P_READY));
        coin = 1'b1; step(); coin = 1'b0;
        check("extra_coin_refund", 32'({o_coin_return, o_ready}), 32'b11);

        // Quick+cold: FILL straight to WASH; lid pause freezes the timer
        program_sel = 2'b11;
        start = 1'b1; step(); start = 1'b0;
        ret0 = n_ret;
        water_full = 1'b1; step(); water_full = 1'b0;
        check("qc_wash_entry", 32'({o_heater_on, o_phase}), 32'(P_WASH));
        check("qc_wash_remaining", 32'(o_remaining), 32'd8);
        step(); step();
        check("wash_before_pause", 32'(o_remaining), 32'd6);
        lid_open = 1'b1; step();
        check("pause_op_drop", 32'({o_wash_operation, o_remaining}), 32'd6);
        step(); step();
        check("pause_frozen", 32'({o_phase, o_remaining}), {12'd0, P_WASH, 16'd6});
        lid_open = 1'b0; step();
        check("resume", 32'({o_wash_operation, o_remaining}), {15'd0, 1'b1, 16'd5});
        measure(P_WASH, n);
        check("wash_tail_len", 32'(n), 32'd5);
        step(); step(); step();
        check("rinse_pass2", 32'({o_phase, o_remaining}), {12'd0, P_RINSE, 16'd3});
        cancel = 1'b1; step(); cancel = 1'b0;
        check("cancel_to_spin", 32'({o_spin_operation, o_remaining}), {15'd0, 1'b1, 16'd5});
        measure(P_SPIN, n);
        check("drain_spin_len", 32'(n), 32'd5);
        check("drain_done", 32'(o_done), 32'd1);
        check("no_refund_after_start", 32'(n_ret - ret0), 32'd0);
        lid_open = 1'b1; step(); lid_open = 1'b0;
        check("idle_after_drain", 32'(o_idle), 32'd1);

        // Fill timeout
        arm_and_start(2'b00);
        check("to_fill_entry", 32'(o_phase), 32'(P_FILL));
        measure(P_FILL, n);
        check("fill_timeout_len", 32'(n), 32'd6);
        check("fault_flags", 32'(flags), 32'(F_FAULT_ONLY));
        coin = 1'b1; start = 1'b1; cancel = 1'b1; step();
        coin = 1'b0; start = 1'b0; cancel = 1'b0;
        check("fault_sticky", 32'({o_phase, flags}), {17'd0, P_FAULT, F_FAULT_ONLY});
        step();
        #2 rst_n = 1'b0;
        #1 check("fault_reset", 32'(flags), 32'(F_IDLE_ONLY));
        step(); rst_n = 1'b1;

        // Asynchronous reset mid-WASH
        arm_and_start(2'b11);
        water_full = 1'b1; step(); water_full = 1'b0;
        step();
        check("pre_reset_wash", 32'(o_wash_operation), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_flags", 32'(flags), 32'(F_IDLE_ONLY));
        check("async_reset_phase", 32'({o_phase, o_remaining}), 32'd0);
        step(); rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
